// File: rtl/sd_pkg.sv
// Shared CIC constants for the sigma-delta decimation path and its models.
package sd_pkg;

  localparam int unsigned CIC_ORDER = 3;

  // Accumulator width that holds R^3 as a signed value without loss.
  function automatic int unsigned cic_acc_w(input int unsigned log2r);
    return 2 + CIC_ORDER * log2r;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb: dout = din - previous din, advanced only when in_valid pulses.
module cic_comb_stage #(
  parameter int unsigned W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] din,
  output logic         out_valid,
  output logic [W-1:0] dout
);

  logic [W-1:0] z;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z         <= '0;
      dout      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        dout <= din - z;
        z    <= din;
      end
    end
  end

endmodule

// File: rtl/sd_cic_decimator.sv
// Third-order CIC decimator for a 1-bit sigma-delta stream, R = 2**LOG2R,
// with a single-entry valid/ready output register and sticky overrun flag.
module sd_cic_decimator
  import sd_pkg::*;
#(
  parameter int unsigned LOG2R = 5,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic [OUT_W-1:0] sample_out,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun
);

  localparam int unsigned ACC_W = cic_acc_w(LOG2R);
  localparam int unsigned SHIFT = ACC_W - OUT_W;

  if (LOG2R < 2 || LOG2R > 8 || OUT_W > ACC_W) begin : g_param_check
    $error("sd_cic_decimator: LOG2R must be 2..8 and OUT_W <= ACC_W");
  end

  logic [ACC_W-1:0] x;
  logic [ACC_W-1:0] i1, i2, i3;
  logic [LOG2R-1:0] cnt;
  logic             strobe;

  assign x = bit_in ? ACC_W'(1) : '1;

  // Each integrator adds its predecessor's pre-update value (one-sample skew).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i1     <= '0;
      i2     <= '0;
      i3     <= '0;
      cnt    <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= bit_valid && (cnt == '1);
      if (bit_valid) begin
        i1  <= i1 + x;
        i2  <= i2 + i1;
        i3  <= i3 + i2;
        cnt <= cnt + LOG2R'(1);
      end
    end
  end

  // strobe is registered, so stage 1 sees i3 after the frame's last update.
  logic             c_valid [CIC_ORDER+1];
  logic [ACC_W-1:0] c_data  [CIC_ORDER+1];

  assign c_valid[0] = strobe;
  assign c_data[0]  = i3;

  for (genvar k = 0; k < CIC_ORDER; k++) begin : g_comb
    cic_comb_stage #(.W(ACC_W)) u_comb (
      .clk      (clk),
      .reset    (reset),
      .in_valid (c_valid[k]),
      .din      (c_data[k]),
      .out_valid(c_valid[k+1]),
      .dout     (c_data[k+1])
    );
  end

  logic signed [ACC_W-1:0] c3;
  logic        [OUT_W-1:0] scaled;

  assign c3     = c_data[CIC_ORDER];
  assign scaled = OUT_W'(c3 >>> SHIFT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (c_valid[CIC_ORDER]) begin
      sample_out   <= scaled;
      sample_valid <= 1'b1;
      if (sample_valid && !sample_ready) overrun <= 1'b1;
    end else if (sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

endmodule
